fcvt_fp: RTL

//   Integer-to-floating-point converter (FCVT.S/D.W/WU/L/LU); the inverse of the FPU float-to-int path.

---
 rtl/fcvt_pkg.sv | 32 +++
 rtl/fcvt_fp_if.sv | 24 ++
 rtl/fcvt_lzc.sv | 17 +
 rtl/fcvt_fp.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fcvt_pkg.sv
// Shared constants for the FPU integer/float converters: rounding modes, FSM
// encoding and width-derived IEEE-754 field sizes.
package fcvt_pkg;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   typedef enum logic [2:0] {
      StIdle,
      StAbs,
      StNorm,
      StRound,
      StDone
   } fcvt_state_e;

   // Only single (32) and double (64) are supported; anything else maps to single.
   function automatic int unsigned mant_bits(input int unsigned w);
      return (w == 64) ? 52 : 23;
   endfunction

   function automatic int unsigned exp_bits(input int unsigned w);
      return (w == 64) ? 11 : 8;
   endfunction

   function automatic int unsigned exp_bias(input int unsigned w);
      return (w == 64) ? 1023 : 127;
   endfunction

endpackage

// File: rtl/fcvt_fp_if.sv
// Operand/result handshake bundle for the int-to-float converter.
interface fcvt_fp_if #(
   parameter int unsigned BUS_WIDTH = 64
);
   logic                 in_valid;
   logic                 in_ready;
   logic [BUS_WIDTH-1:0] int_in;
   logic                 is_signed;
   logic [2:0]           rm;
   logic                 out_valid;
   logic                 out_ready;
   logic [BUS_WIDTH-1:0] fp_out;
   logic                 nx;

   modport master (
      output in_valid, int_in, is_signed, rm, out_ready,
      input  in_ready, out_valid, fp_out, nx
   );

   modport slave (
      input  in_valid, int_in, is_signed, rm, out_ready,
      output in_ready, out_valid, fp_out, nx
   );
endinterface

// File: rtl/fcvt_lzc.sv
// Combinational leading-zero counter; an all-zero input yields W.
module fcvt_lzc #(
   parameter int unsigned W = 64
) (
   input  logic [W-1:0]         val,
   output logic [$clog2(W):0]   cnt
);
   localparam int unsigned CW = $clog2(W) + 1;

   // Scanning upward, the last set bit seen is the most significant one.
   always_comb begin
      cnt = CW'(W);
      for (int i = 0; i < int'(W); i++) begin
         if (val[i]) cnt = CW'(int'(W) - 1 - i);
      end
   end
endmodule

// File: rtl/fcvt_fp.sv
// Multi-cycle integer-to-float converter (FCVT.S/D.W/WU/L/LU) with
// valid/ready on both sides and IEEE rounding.
module fcvt_fp
   import fcvt_pkg::*;
#(
   parameter int unsigned BUS_WIDTH = 64
) (
   input  logic     clk,
   input  logic     rst,
   fcvt_fp_if.slave bus
);
   localparam int unsigned W    = BUS_WIDTH;
   localparam int unsigned MANT = mant_bits(W);
   localparam int unsigned EXPW = exp_bits(W);
   localparam int unsigned BIAS = exp_bias(W);
   localparam int unsigned LZW  = $clog2(W) + 1;
   localparam logic [EXPW-1:0] EXP_TOP = EXPW'(BIAS + W - 1);

   fcvt_state_e     state;
   logic [W-1:0]    op_q;
   logic            is_signed_q;
   logic [2:0]      rm_q;
   logic            sign_q;
   logic            zero_q;
   logic [W-1:0]    mag_q;
   logic [W-1:0]    nmag_q;
   logic [EXPW-1:0] exp_q;
   logic [W-1:0]    fp_q;
   logic            nx_q;
   logic            out_valid_q;

   logic [LZW-1:0]  lz;
   logic [EXPW-1:0] exp_norm;
   logic [MANT-1:0] kept;
   logic            guard;
   logic            sticky;
   logic            inc;
   logic [MANT:0]   sum;
   logic [EXPW-1:0] exp_rnd;
   logic [W-1:0]    packed_fp;
   logic            op_sign;

   fcvt_lzc #(.W(W)) u_lzc (
      .val (mag_q),
      .cnt (lz)
   );

   assign bus.in_ready  = (state == StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.fp_out    = fp_q;
   assign bus.nx        = nx_q;

   assign op_sign  = is_signed_q & op_q[W-1];
   assign exp_norm = EXP_TOP - {{(EXPW - LZW){1'b0}}, lz};

   assign kept   = nmag_q[W-2 -: MANT];
   assign guard  = nmag_q[W-2-MANT];
   assign sticky = |nmag_q[W-3-MANT:0];

   always_comb begin
      inc = 1'b0;
      case (rm_q)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign_q & (guard | sticky);
         RM_RUP:  inc = ~sign_q & (guard | sticky);
         RM_RMM:  inc = guard;
         default: inc = guard & (sticky | kept[0]);
      endcase
   end

   // A carry out of the mantissa leaves the low bits zero, so only the exponent needs bumping.
   assign sum       = {1'b0, kept} + {{MANT{1'b0}}, inc};
   assign exp_rnd   = exp_q + {{(EXPW - 1){1'b0}}, sum[MANT]};
   assign packed_fp = {sign_q, exp_rnd, sum[MANT-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         op_q        <= '0;
         is_signed_q <= 1'b0;
         rm_q        <= '0;
         sign_q      <= 1'b0;
         zero_q      <= 1'b0;
         mag_q       <= '0;
         nmag_q      <= '0;
         exp_q       <= '0;
         fp_q        <= '0;
         nx_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (bus.in_valid) begin
                  op_q        <= bus.int_in;
                  is_signed_q <= bus.is_signed;
                  rm_q        <= bus.rm;
                  state       <= StAbs;
               end
            end
            StAbs: begin
               sign_q <= op_sign;
               mag_q  <= op_sign ? -op_q : op_q;
               zero_q <= (op_q == '0);
               state  <= StNorm;
            end
            StNorm: begin
               nmag_q <= mag_q << lz;
               exp_q  <= exp_norm;
               state  <= StRound;
            end
            StRound: begin
               if (zero_q) begin
                  fp_q <= '0;
                  nx_q <= 1'b0;
               end else begin
                  fp_q <= packed_fp;
                  nx_q <= guard | sticky;
               end
               out_valid_q <= 1'b1;
               state       <= StDone;
            end
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end
endmodule
